// File: rtl/digitalclock_alarm_pkg.sv
// Shared defaults, ring state type and width helper for the digitalclock_alarm clock.
package digitalclock_alarm_pkg;

    localparam int DEF_TICK_DIV    = 1;
    localparam int DEF_SEC_PER_MIN = 60;
    localparam int DEF_MIN_PER_HR  = 60;
    localparam int DEF_HR_PER_DAY  = 24;
    localparam int DEF_RING_SECS   = 30;

    typedef enum logic {
        RING_IDLE   = 1'b0,
        RING_ACTIVE = 1'b1
    } ring_state_e;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digitalclock_alarm_mod_counter.sv
// Modulo-M counter with enable, synchronous load (out-of-range loads become 0),
// carry-out on wrap and a look-ahead of the value it will hold after the next edge.
module digitalclock_alarm_mod_counter #(
    parameter int M = 60,
    parameter int W = 6
) (
    input  logic         Clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         carry
);

    logic at_max;
    logic ld_oor;

    assign at_max = (cnt == W'(M - 1));
    assign ld_oor = ({1'b0, ld_val} >= (W + 1)'(M));
    assign carry  = en && !ld && at_max;

    always_comb begin
        cnt_nxt = cnt;
        if (ld) begin
            cnt_nxt = ld_oor ? '0 : ld_val;
        end else if (en) begin
            cnt_nxt = at_max ? '0 : cnt + W'(1);
        end
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/digitalclock_alarm.sv
// Time-of-day clock with tick prescaler, run/stop, time load, alarm with ack and
// auto-timeout, day-wrap pulse and a 12/24 h display view.
//
//   state       | meaning
//   RING_IDLE   | alarm_ring low, waiting for a match
//   RING_ACTIVE | alarm_ring high, ring_timer counts remaining ticks down to 0
module digitalclock_alarm
    import digitalclock_alarm_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int SEC_PER_MIN = DEF_SEC_PER_MIN,
    parameter int MIN_PER_HR  = DEF_MIN_PER_HR,
    parameter int HR_PER_DAY  = DEF_HR_PER_DAY,
    parameter int RING_SECS   = DEF_RING_SECS,
    parameter int SW          = cnt_width(SEC_PER_MIN),
    parameter int MW          = cnt_width(MIN_PER_HR),
    parameter int HW          = cnt_width(HR_PER_DAY)
) (
    input  logic          Clk,
    input  logic          reset_n,
    input  logic          run,
    input  logic          load,
    input  logic [SW-1:0] load_sec,
    input  logic [MW-1:0] load_min,
    input  logic [HW-1:0] load_hr,
    input  logic          alarm_set,
    input  logic [MW-1:0] alarm_min,
    input  logic [HW-1:0] alarm_hr,
    input  logic          alarm_en,
    input  logic          alarm_ack,
    input  logic          mode_12h,
    output logic [SW-1:0] seconds,
    output logic [MW-1:0] minutes,
    output logic [HW-1:0] hours,
    output logic [HW-1:0] hours_disp,
    output logic          pm,
    output logic          tick,
    output logic          day_wrap,
    output logic          alarm_ring
);

    localparam int PW  = cnt_width(TICK_DIV);
    localparam int RTW = cnt_width(RING_SECS);

    logic [PW-1:0]  pre_cnt;
    logic           advance;
    logic           step;
    logic [SW-1:0]  sec_nxt;
    logic [MW-1:0]  min_nxt;
    logic [HW-1:0]  hr_nxt;
    logic           sec_carry;
    logic           min_carry;
    logic           hr_carry;
    logic [MW-1:0]  alarm_min_r;
    logic [HW-1:0]  alarm_hr_r;
    logic           match;
    ring_state_e    ring_st;
    ring_state_e    ring_st_nxt;
    logic [RTW-1:0] ring_timer;
    logic [RTW-1:0] ring_timer_nxt;

    assign advance = run && (pre_cnt == PW'(TICK_DIV - 1));
    assign step    = advance && !load;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
        end else if (load) begin
            pre_cnt <= '0;
        end else if (run) begin
            pre_cnt <= advance ? '0 : pre_cnt + PW'(1);
        end
    end

    digitalclock_alarm_mod_counter #(.M(SEC_PER_MIN), .W(SW)) u_sec (
        .Clk(Clk), .reset_n(reset_n), .en(step), .ld(load), .ld_val(load_sec),
        .cnt(seconds), .cnt_nxt(sec_nxt), .carry(sec_carry)
    );

    digitalclock_alarm_mod_counter #(.M(MIN_PER_HR), .W(MW)) u_min (
        .Clk(Clk), .reset_n(reset_n), .en(sec_carry), .ld(load), .ld_val(load_min),
        .cnt(minutes), .cnt_nxt(min_nxt), .carry(min_carry)
    );

    digitalclock_alarm_mod_counter #(.M(HR_PER_DAY), .W(HW)) u_hr (
        .Clk(Clk), .reset_n(reset_n), .en(min_carry), .ld(load), .ld_val(load_hr),
        .cnt(hours), .cnt_nxt(hr_nxt), .carry(hr_carry)
    );

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            tick        <= 1'b0;
            day_wrap    <= 1'b0;
            alarm_min_r <= '0;
            alarm_hr_r  <= '0;
        end else begin
            tick     <= step;
            day_wrap <= hr_carry;
            if (alarm_set) begin
                alarm_min_r <= ({1'b0, alarm_min} >= (MW + 1)'(MIN_PER_HR)) ? '0 : alarm_min;
                alarm_hr_r  <= ({1'b0, alarm_hr} >= (HW + 1)'(HR_PER_DAY)) ? '0 : alarm_hr;
            end
        end
    end

    // Compare against the time about to become visible so the ring rises with it.
    assign match = step && alarm_en && (sec_nxt == '0)
                   && (min_nxt == alarm_min_r) && (hr_nxt == alarm_hr_r);

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            ring_st    <= RING_IDLE;
            ring_timer <= '0;
        end else begin
            ring_st    <= ring_st_nxt;
            ring_timer <= ring_timer_nxt;
        end
    end

    always_comb begin
        ring_st_nxt    = ring_st;
        ring_timer_nxt = ring_timer;
        if (match) begin
            ring_st_nxt    = RING_ACTIVE;
            ring_timer_nxt = RTW'(RING_SECS - 1);
        end else if (ring_st == RING_ACTIVE) begin
            if (alarm_ack || !alarm_en) begin
                ring_st_nxt = RING_IDLE;
            end else if (step) begin
                if (ring_timer == '0) begin
                    ring_st_nxt = RING_IDLE;
                end else begin
                    ring_timer_nxt = ring_timer - RTW'(1);
                end
            end
        end
    end

    assign alarm_ring = (ring_st == RING_ACTIVE);

    always_comb begin
        hours_disp = hours;
        if (mode_12h && (HR_PER_DAY == 24)) begin
            if (hours == '0) begin
                hours_disp = HW'(12);
            end else if (hours > HW'(12)) begin
                hours_disp = hours - HW'(12);
            end
        end
    end

    assign pm = (32'(hours) >= 32'd12);

endmodule

// File: tb/tb_digitalclock_alarm.sv
// Randomized and directed bench for digitalclock_alarm: two instances (1 and 4 clocks
// per tick) share stimulus and are checked each cycle against a seconds-of-day model.
module tb_digitalclock_alarm;

    localparam int RING = 30;

    logic       Clk;
    logic       reset_n;
    logic       run;
    logic       load;
    logic [5:0] load_sec;
    logic [5:0] load_min;
    logic [4:0] load_hr;
    logic       alarm_set;
    logic [5:0] alarm_min;
    logic [4:0] alarm_hr;
    logic       alarm_en;
    logic       alarm_ack;
    logic       mode_12h;

    logic [5:0] sec_a, min_a, sec_b, min_b;
    logic [4:0] hr_a, disp_a, hr_b, disp_b;
    logic       pm_a, tick_a, wrap_a, ring_a;
    logic       pm_b, tick_b, wrap_b, ring_b;

    int vectors;
    int miscompares;
    bit chk_en;

    int m_t     [2];
    int m_pre   [2];
    int m_am    [2];
    int m_ah    [2];
    int m_rleft [2];
    bit m_ring  [2];
    bit m_tick  [2];
    bit m_wrap  [2];

    digitalclock_alarm u_dut1 (
        .Clk(Clk), .reset_n(reset_n), .run(run), .load(load),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
        .alarm_set(alarm_set), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack), .mode_12h(mode_12h),
        .seconds(sec_a), .minutes(min_a), .hours(hr_a), .hours_disp(disp_a),
        .pm(pm_a), .tick(tick_a), .day_wrap(wrap_a), .alarm_ring(ring_a)
    );

    digitalclock_alarm #(.TICK_DIV(4)) u_dut4 (
        .Clk(Clk), .reset_n(reset_n), .run(run), .load(load),
        .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
        .alarm_set(alarm_set), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack), .mode_12h(mode_12h),
        .seconds(sec_b), .minutes(min_b), .hours(hr_b), .hours_disp(disp_b),
        .pm(pm_b), .tick(tick_b), .day_wrap(wrap_b), .alarm_ring(ring_b)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clampv(input int v, input int m);
        return (v >= m) ? 0 : v;
    endfunction

    function automatic int exp_disp(input int h, input bit m12);
        if (!m12) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    task automatic model_step(input int k, input int div);
        bit adv;
        bit match;
        adv = run && (m_pre[k] == div - 1);
        match = 1'b0;
        m_tick[k] = 1'b0;
        m_wrap[k] = 1'b0;
        if (load) begin
            m_t[k] = clampv(int'(load_hr), 24) * 3600 + clampv(int'(load_min), 60) * 60
                     + clampv(int'(load_sec), 60);
            m_pre[k] = 0;
        end else begin
            if (run) m_pre[k] = adv ? 0 : m_pre[k] + 1;
            if (adv) begin
                m_t[k] = (m_t[k] + 1) % 86400;
                m_tick[k] = 1'b1;
                m_wrap[k] = (m_t[k] == 0);
                match = alarm_en && (m_t[k] == m_ah[k] * 3600 + m_am[k] * 60);
            end
        end
        if (match) begin
            m_ring[k] = 1'b1;
            m_rleft[k] = RING;
        end else if (m_ring[k]) begin
            if (alarm_ack || !alarm_en) begin
                m_ring[k] = 1'b0;
            end else if (m_tick[k]) begin
                m_rleft[k]--;
                if (m_rleft[k] == 0) m_ring[k] = 1'b0;
            end
        end
        if (alarm_set) begin
            m_am[k] = clampv(int'(alarm_min), 60);
            m_ah[k] = clampv(int'(alarm_hr), 24);
        end
    endtask

    always @(posedge Clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_t[k] = 0; m_pre[k] = 0; m_am[k] = 0; m_ah[k] = 0; m_rleft[k] = 0;
                m_ring[k] = 1'b0; m_tick[k] = 1'b0; m_wrap[k] = 1'b0;
            end else begin
                model_step(k, (k == 0) ? 1 : 4);
            end
        end
    end

    task automatic cmp_inst(input int k, input int s, input int mi, input int h, input int d,
                            input int p, input int tk, input int w, input int r);
        int hh;
        hh = m_t[k] / 3600;
        check($sformatf("u%0d.seconds", k), s, m_t[k] % 60);
        check($sformatf("u%0d.minutes", k), mi, (m_t[k] / 60) % 60);
        check($sformatf("u%0d.hours", k), h, hh);
        check($sformatf("u%0d.hours_disp", k), d, exp_disp(hh, mode_12h));
        check($sformatf("u%0d.pm", k), p, (hh >= 12) ? 1 : 0);
        check($sformatf("u%0d.tick", k), tk, int'(m_tick[k]));
        check($sformatf("u%0d.day_wrap", k), w, int'(m_wrap[k]));
        check($sformatf("u%0d.alarm_ring", k), r, int'(m_ring[k]));
    endtask

    always @(negedge Clk) begin
        if (chk_en) begin
            cmp_inst(0, int'(sec_a), int'(min_a), int'(hr_a), int'(disp_a),
                     int'(pm_a), int'(tick_a), int'(wrap_a), int'(ring_a));
            cmp_inst(1, int'(sec_b), int'(min_b), int'(hr_b), int'(disp_b),
                     int'(pm_b), int'(tick_b), int'(wrap_b), int'(ring_b));
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_time(input int h, input int m, input int s);
        load = 1'b1;
        load_hr = 5'(h);
        load_min = 6'(m);
        load_sec = 6'(s);
        cyc();
        load = 1'b0;
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        check({tag, ".hours"}, int'(hr_a), h);
        check({tag, ".minutes"}, int'(min_a), m);
        check({tag, ".seconds"}, int'(sec_a), s);
    endtask

    int t4_hr   [4] = '{0, 12, 13, 23};
    int t4_disp [4] = '{12, 12, 1, 11};
    int t4_pm   [4] = '{0, 1, 1, 1};
    int ticks4;

    initial begin
        vectors = 0; miscompares = 0; chk_en = 1'b0;
        reset_n = 1'b0; run = 1'b0; load = 1'b0;
        load_sec = '0; load_min = '0; load_hr = '0;
        alarm_set = 1'b0; alarm_min = '0; alarm_hr = '0;
        alarm_en = 1'b0; alarm_ack = 1'b0; mode_12h = 1'b0;
        cyc();
        cyc();
        chk_time("reset", 0, 0, 0);
        check("reset.alarm_ring", int'(ring_a), 0);
        reset_n = 1'b1;
        chk_en = 1'b1;

        // day wrap
        run = 1'b1;
        load_time(23, 59, 58);
        chk_time("wrap.load", 23, 59, 58);
        check("wrap.load_tick", int'(tick_a), 0);
        cyc();
        chk_time("wrap.s59", 23, 59, 59);
        check("wrap.tick", int'(tick_a), 1);
        check("wrap.no_wrap", int'(wrap_a), 0);
        cyc();
        chk_time("wrap.zero", 0, 0, 0);
        check("wrap.day_wrap", int'(wrap_a), 1);
        cyc();
        check("wrap.day_wrap_1cyc", int'(wrap_a), 0);

        // prescaler on the TICK_DIV=4 instance
        load_time(0, 0, 0);
        ticks4 = 0;
        repeat (42) begin
            cyc();
            if (tick_b) ticks4++;
        end
        check("div4.ticks", ticks4, 10);
        check("div4.seconds", int'(sec_b), 10);
        run = 1'b0;
        repeat (10) begin
            cyc();
            if (tick_b) ticks4++;
        end
        check("div4.frozen_sec", int'(sec_b), 10);
        check("div4.frozen_ticks", ticks4, 10);
        run = 1'b1;
        cyc();
        check("div4.resume_pre", int'(sec_b), 10);
        cyc();
        check("div4.resume_sec", int'(sec_b), 11);
        check("div4.resume_tick", int'(tick_b), 1);

        // alarm with ack, then timeout
        alarm_set = 1'b1; alarm_min = 6'd30; alarm_hr = 5'd7; alarm_en = 1'b1;
        load_time(7, 29, 59);
        alarm_set = 1'b0;
        check("alarm.before", int'(ring_a), 0);
        cyc();
        chk_time("alarm.match", 7, 30, 0);
        check("alarm.ring", int'(ring_a), 1);
        alarm_ack = 1'b1;
        cyc();
        alarm_ack = 1'b0;
        check("alarm.ack", int'(ring_a), 0);
        load_time(7, 29, 59);
        cyc();
        check("alarm.ring2", int'(ring_a), 1);
        repeat (29) cyc();
        check("alarm.hold29", int'(ring_a), 1);
        check("alarm.hold29_sec", int'(sec_a), 29);
        cyc();
        check("alarm.timeout", int'(ring_a), 0);

        // 12 h view
        run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mode_12h = 1'b0;
            load_time(t4_hr[i], 15, 0);
            mode_12h = 1'b1;
            #1;
            check($sformatf("disp12.h%0d", t4_hr[i]), int'(disp_a), t4_disp[i]);
            check($sformatf("pm12.h%0d", t4_hr[i]), int'(pm_a), t4_pm[i]);
        end
        mode_12h = 1'b0;
        #1;
        check("disp24.h23", int'(disp_a), 23);
        check("pm24.h23", int'(pm_a), 1);

        // out-of-range load and load beating advance
        load_time(30, 5, 61);
        chk_time("oor", 0, 5, 0);
        run = 1'b1;
        load_time(10, 20, 30);
        chk_time("ld_adv", 10, 20, 30);
        check("ld_adv.tick", int'(tick_a), 0);

        // async reset between edges
        cyc();
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        chk_time("areset", 0, 0, 0);
        check("areset.tick", int'(tick_a), 0);
        check("areset.ring", int'(ring_a), 0);
        cyc();
        reset_n = 1'b1;
        cyc();
        chk_time("areset.resume", 0, 0, 1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            load = ($urandom_range(0, 39) == 0);
            run = ($urandom_range(0, 9) != 0);
            alarm_set = 1'b0;
            if (load) begin
                load_hr = 5'($urandom_range(0, 31));
                load_min = 6'($urandom_range(0, 63));
                load_sec = 6'($urandom_range(40, 63));
                if ($urandom_range(0, 1) == 1) begin
                    alarm_set = 1'b1;
                    alarm_hr = load_hr;
                    alarm_min = (load_min >= 6'd59) ? 6'd0 : load_min + 6'd1;
                end
            end else if ($urandom_range(0, 99) == 0) begin
                alarm_set = 1'b1;
                alarm_hr = 5'($urandom_range(0, 31));
                alarm_min = 6'($urandom_range(0, 63));
            end
            alarm_ack = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) alarm_en = ~alarm_en;
            mode_12h = 1'($urandom_range(0, 1));
            reset_n = ($urandom_range(0, 999) != 0);
            cyc();
        end
        reset_n = 1'b1;
        load = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
